sa_ram_fifo_ctrl_16x65: RTL

- FIFO controller that owns and drives an external 16x65 two-port RAM macro: write address/enable/data, registered read address (latched by re), and output register (latched by ore).
- Presents a valid/ready push interface and a valid/ready pop interface to the datapath.
- Hides the RAM's 2-stage read pipeline so the pop side sees full throughput with no bubbles.
- Sits between a producer and the sa_ram_rwsp_* macro it is paired with.

---
 rtl/sa_ram_fifo_ctrl_16x65_if.sv | 21 ++
 rtl/sa_ram_fifo_ctrl_16x65.sv | 68 ++++++
 2 files changed

// File: rtl/sa_ram_fifo_ctrl_16x65_if.sv
// sa_ram_fifo_ctrl_16x65_if: push and pop valid/ready handshakes of the RAM-backed FIFO
interface sa_ram_fifo_ctrl_16x65_if #(
    parameter int DW = 65
);
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;

    modport master (
        output wr_pvld, wr_pd, rd_prdy,
        input  wr_prdy, rd_pvld, rd_pd
    );

    modport slave (
        input  wr_pvld, wr_pd, rd_prdy,
        output wr_prdy, rd_pvld, rd_pd
    );
endinterface

// File: rtl/sa_ram_fifo_ctrl_16x65.sv
// sa_ram_fifo_ctrl_16x65: valid/ready FIFO controller driving an external 16x65 RAM with a 2-stage read pipeline
module sa_ram_fifo_ctrl_16x65 #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    sa_ram_fifo_ctrl_16x65_if.slave  io,
    output logic [4:0]               fifo_cnt,
    output logic                     ram_we,
    output logic [AW-1:0]            ram_wa,
    output logic [DW-1:0]            ram_di,
    output logic                     ram_re,
    output logic [AW-1:0]            ram_ra,
    output logic                     ram_ore,
    input  logic [DW-1:0]            ram_dout,
    input  logic [31:0]              pwrbus_ram_pd_in,
    output logic [31:0]              pwrbus_ram_pd
);
    localparam logic [4:0] FULL = 5'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    ram_occ;
    logic [4:0]    pending;
    logic          s1_vld;
    logic          s2_vld;
    logic          accept;
    logic          pop;

    // A RAM slot stays occupied until ore captures it, so the write pointer can never reach the latched read address
    assign io.wr_prdy    = !rst && (ram_occ < FULL);
    assign io.rd_pvld    = s2_vld;
    assign io.rd_pd      = ram_dout;
    assign pwrbus_ram_pd = pwrbus_ram_pd_in;
    assign ram_wa        = wr_ptr;
    assign ram_di        = io.wr_pd;
    assign ram_ra        = rd_ptr;

    // Advance the read pipeline whenever the downstream stage is empty or draining; hold both RAM registers on stall
    always_comb begin
        accept   = io.wr_pvld && io.wr_prdy;
        pop      = s2_vld && io.rd_prdy;
        pending  = ram_occ - {4'b0, s1_vld};
        ram_we   = accept;
        ram_ore  = s1_vld && (!s2_vld || io.rd_prdy);
        ram_re   = !rst && (pending != 5'd0) && (!s1_vld || ram_ore);
        fifo_cnt = ram_occ + {4'b0, s2_vld};
    end

    // Pointers, RAM occupancy and pipeline stage valids
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_occ <= '0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (ram_re) rd_ptr <= rd_ptr + AW'(1);
            ram_occ <= ram_occ + {4'b0, accept} - {4'b0, ram_ore};
            s1_vld  <= ram_re || (s1_vld && !ram_ore);
            s2_vld  <= ram_ore || (s2_vld && !pop);
        end
    end
endmodule
